// File: rtl/control_p4_pkg.sv
// Shared types for the control-plane AXI4-Lite router:
// FSM states, AXI response codes, slave-select decode.
package control_p4_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RSP,
      WR_DONE,
      RD_REQ,
      RD_RSP,
      RD_DONE
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic [1:0] sel_field(input logic [31:0] off,
                                            input int unsigned lsb);
      return off[lsb +: 2];
   endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear
// and flags expiry on the last allowed cycle.
module axil_watchdog #(
   parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(C_TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(C_TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && cnt_q != LAST) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire_o = enable_i & ~clear_i & (cnt_q == LAST);

endmodule

// File: rtl/control_axil_vswitch_router.sv
// AXI4-Lite router: one host master to N virtual-switch slaves,
// one transaction at a time, with decode errors and timeouts.
module control_axil_vswitch_router
   import control_p4_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_NUM_SLAVES       = 4,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDRESS = '0,
   parameter int unsigned C_SEL_LSB          = 16,
   parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
   input  logic M_AXI_ACLK,
   input  logic M_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   input  logic M_AXI_AWVALID,
   output logic M_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   input  logic M_AXI_WVALID,
   output logic M_AXI_WREADY,
   output logic [1:0] M_AXI_BRESP,
   output logic M_AXI_BVALID,
   input  logic M_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   input  logic M_AXI_ARVALID,
   output logic M_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   output logic [1:0] M_AXI_RRESP,
   output logic M_AXI_RVALID,
   input  logic M_AXI_RREADY,
   output logic [C_NUM_SLAVES*C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   output logic [C_NUM_SLAVES-1:0] S_AXI_AWVALID,
   input  logic [C_NUM_SLAVES-1:0] S_AXI_AWREADY,
   output logic [C_NUM_SLAVES*C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   output logic [C_NUM_SLAVES*C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   output logic [C_NUM_SLAVES-1:0] S_AXI_WVALID,
   input  logic [C_NUM_SLAVES-1:0] S_AXI_WREADY,
   input  logic [2*C_NUM_SLAVES-1:0] S_AXI_BRESP,
   input  logic [C_NUM_SLAVES-1:0] S_AXI_BVALID,
   output logic [C_NUM_SLAVES-1:0] S_AXI_BREADY,
   output logic [C_NUM_SLAVES*C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   output logic [C_NUM_SLAVES-1:0] S_AXI_ARVALID,
   input  logic [C_NUM_SLAVES-1:0] S_AXI_ARREADY,
   input  logic [C_NUM_SLAVES*C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   input  logic [2*C_NUM_SLAVES-1:0] S_AXI_RRESP,
   input  logic [C_NUM_SLAVES-1:0] S_AXI_RVALID,
   output logic [C_NUM_SLAVES-1:0] S_AXI_RREADY,
   output logic [15:0] STAT_TIMEOUT_CNT
);

   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
   localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned SW = DW / 8;

   state_e state_q, state_d;
   logic prio_q, prio_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [SW-1:0] wstrb_q, wstrb_d;
   logic [1:0] sel_q, sel_d, resp_q, resp_d;
   logic aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
   logic drain_b_q, drain_b_d, drain_r_q, drain_r_d;
   logic [15:0] tocnt_q, tocnt_d;

   logic both, take_wr, take_rd, accept, m_map;
   logic [AW-1:0] m_addr, m_off;
   logic [1:0] m_sel;
   int unsigned si;
   logic [1:0] s_bresp, s_rresp;
   logic [DW-1:0] s_rdata;
   logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic wd_clr, wd_en, wd_exp, in_wr;

   // prio_q = 0 means a write wins when both directions are pending
   assign both    = M_AXI_AWVALID & M_AXI_WVALID & M_AXI_ARVALID;
   assign take_wr = (state_q == IDLE) & M_AXI_AWVALID & M_AXI_WVALID
                  & (~M_AXI_ARVALID | ~prio_q);
   assign take_rd = (state_q == IDLE) & M_AXI_ARVALID & ~take_wr;
   assign accept  = take_wr | take_rd;
   assign m_addr  = take_wr ? M_AXI_AWADDR : M_AXI_ARADDR;
   assign m_off   = m_addr ^ C_BASE_ADDRESS;
   assign m_sel   = sel_field(32'(m_off), C_SEL_LSB);
   assign m_map   = (m_off >> (C_SEL_LSB + 2)) == '0;

   assign si      = 32'(sel_q);
   assign s_bresp = S_AXI_BRESP[si*2 +: 2];
   assign s_rresp = S_AXI_RRESP[si*2 +: 2];
   assign s_rdata = S_AXI_RDATA[si*DW +: DW];

   assign aw_hs = (state_q == WR_REQ) & aw_pend_q & S_AXI_AWREADY[sel_q];
   assign w_hs  = (state_q == WR_REQ) & w_pend_q & S_AXI_WREADY[sel_q];
   assign ar_hs = (state_q == RD_REQ) & S_AXI_ARREADY[sel_q];
   assign b_hs  = (state_q == WR_RSP) & S_AXI_BVALID[sel_q];
   assign r_hs  = (state_q == RD_RSP) & S_AXI_RVALID[sel_q];

   assign in_wr  = (state_q == WR_REQ) | (state_q == WR_RSP);
   assign wd_en  = in_wr | (state_q == RD_REQ) | (state_q == RD_RSP);
   assign wd_clr = accept | aw_hs | w_hs | ar_hs | b_hs | r_hs;

   axil_watchdog #(
      .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
   ) u_wd (
      .clk_i   (M_AXI_ACLK),
      .rst_i   (M_AXI_ARESET),
      .clear_i (wd_clr),
      .enable_i(wd_en),
      .expire_o(wd_exp)
   );

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_q   <= IDLE;
         prio_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         sel_q     <= '0;
         resp_q    <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         drain_b_q <= 1'b0;
         drain_r_q <= 1'b0;
         tocnt_q   <= '0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         sel_q     <= sel_d;
         resp_q    <= resp_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         drain_b_q <= drain_b_d;
         drain_r_q <= drain_r_d;
         tocnt_q   <= tocnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      sel_d     = sel_q;
      resp_d    = resp_q;
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      drain_b_d = drain_b_q;
      drain_r_d = drain_r_q;
      tocnt_d   = tocnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d    = m_addr;
               wdata_d   = M_AXI_WDATA;
               wstrb_d   = M_AXI_WSTRB;
               sel_d     = m_sel;
               drain_b_d = 1'b0;
               drain_r_d = 1'b0;
               if (both) prio_d = ~prio_q;
               if (!m_map) begin
                  resp_d  = RESP_DECERR;
                  rdata_d = '0;
                  state_d = take_wr ? WR_DONE : RD_DONE;
               end else if (take_wr) begin
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  state_d = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            if (aw_hs) aw_pend_d = 1'b0;
            if (w_hs) w_pend_d = 1'b0;
            if ((~aw_pend_q | aw_hs) & (~w_pend_q | w_hs)) state_d = WR_RSP;
         end
         WR_RSP: begin
            if (b_hs) begin
               resp_d  = s_bresp;
               state_d = WR_DONE;
            end
         end
         RD_REQ: begin
            if (ar_hs) state_d = RD_RSP;
         end
         RD_RSP: begin
            if (r_hs) begin
               resp_d  = s_rresp;
               rdata_d = s_rdata;
               state_d = RD_DONE;
            end
         end
         WR_DONE: if (M_AXI_BREADY) state_d = IDLE;
         RD_DONE: if (M_AXI_RREADY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // The aborted slave keeps its response ready up until the next accept
      if (wd_exp) begin
         aw_pend_d = 1'b0;
         w_pend_d  = 1'b0;
         resp_d    = RESP_SLVERR;
         rdata_d   = '0;
         drain_b_d = in_wr;
         drain_r_d = ~in_wr;
         tocnt_d   = (tocnt_q == 16'hFFFF) ? tocnt_q : tocnt_q + 16'd1;
         state_d   = in_wr ? WR_DONE : RD_DONE;
      end
   end

   always_comb begin
      M_AXI_AWREADY = take_wr & ~M_AXI_ARESET;
      M_AXI_WREADY  = take_wr & ~M_AXI_ARESET;
      M_AXI_ARREADY = take_rd & ~M_AXI_ARESET;
      M_AXI_BVALID  = (state_q == WR_DONE);
      M_AXI_RVALID  = (state_q == RD_DONE);
      M_AXI_BRESP   = resp_q;
      M_AXI_RRESP   = resp_q;
      M_AXI_RDATA   = rdata_q;
      S_AXI_AWADDR  = {C_NUM_SLAVES{addr_q}};
      S_AXI_ARADDR  = {C_NUM_SLAVES{addr_q}};
      S_AXI_WDATA   = {C_NUM_SLAVES{wdata_q}};
      S_AXI_WSTRB   = {C_NUM_SLAVES{wstrb_q}};
      S_AXI_AWVALID = '0;
      S_AXI_WVALID  = '0;
      S_AXI_ARVALID = '0;
      S_AXI_BREADY  = '0;
      S_AXI_RREADY  = '0;
      S_AXI_AWVALID[sel_q] = (state_q == WR_REQ) & aw_pend_q;
      S_AXI_WVALID[sel_q]  = (state_q == WR_REQ) & w_pend_q;
      S_AXI_ARVALID[sel_q] = (state_q == RD_REQ);
      S_AXI_BREADY[sel_q]  = (state_q == WR_RSP) | drain_b_q;
      S_AXI_RREADY[sel_q]  = (state_q == RD_RSP) | drain_r_q;
      STAT_TIMEOUT_CNT = tocnt_q;
   end

endmodule

// File: tb/tb_control_axil_vswitch_router.sv
// Directed bench for the AXI4-Lite vswitch router with simple
// behavioural slaves and a table of host transactions.
module tb_control_axil_vswitch_router;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
   logic [3:0] m_wstrb;
   logic m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
   logic m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
   logic [1:0] m_bresp, m_rresp;
   logic [127:0] s_awaddr, s_araddr, s_wdata, s_rdata;
   logic [15:0] s_wstrb, stat;
   logic [3:0] s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
   logic [3:0] s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
   logic [7:0] s_bresp, s_rresp;
   logic [3:0] w_en = 4'hF;

   control_axil_vswitch_router #(
      .C_TIMEOUT_CYCLES(16)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .M_AXI_AWADDR(m_awaddr), .M_AXI_AWVALID(m_awvalid),
      .M_AXI_AWREADY(m_awready), .M_AXI_WDATA(m_wdata),
      .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid),
      .M_AXI_WREADY(m_wready), .M_AXI_BRESP(m_bresp),
      .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
      .M_AXI_ARADDR(m_araddr), .M_AXI_ARVALID(m_arvalid),
      .M_AXI_ARREADY(m_arready), .M_AXI_RDATA(m_rdata),
      .M_AXI_RRESP(m_rresp), .M_AXI_RVALID(m_rvalid),
      .M_AXI_RREADY(m_rready),
      .S_AXI_AWADDR(s_awaddr), .S_AXI_AWVALID(s_awvalid),
      .S_AXI_AWREADY(s_awready), .S_AXI_WDATA(s_wdata),
      .S_AXI_WSTRB(s_wstrb), .S_AXI_WVALID(s_wvalid),
      .S_AXI_WREADY(s_wready), .S_AXI_BRESP(s_bresp),
      .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready),
      .S_AXI_ARADDR(s_araddr), .S_AXI_ARVALID(s_arvalid),
      .S_AXI_ARREADY(s_arready), .S_AXI_RDATA(s_rdata),
      .S_AXI_RRESP(s_rresp), .S_AXI_RVALID(s_rvalid),
      .S_AXI_RREADY(s_rready), .STAT_TIMEOUT_CNT(stat)
   );

   // Slave models: slave 0 answers EXOKAY, slave 3 reads take 5 extra cycles
   function automatic logic [31:0] rdval(input int i);
      return (i == 3) ? 32'h1234_5678 : 32'hA000_0000 + 32'(i);
   endfunction
   function automatic logic [1:0] rsp(input int i);
      return (i == 0) ? 2'b01 : 2'b00;
   endfunction
   function automatic int rdly(input int i);
      return (i == 3) ? 5 : 0;
   endfunction

   logic [3:0] bvld, rvld, got_aw, got_w, rpend;
   int rcnt[4];
   int vcnt[4];
   logic [31:0] last_wd[4];
   logic [31:0] last_addr[4];

   assign s_awready = 4'hF;
   assign s_arready = 4'hF;
   assign s_wready  = w_en;
   assign s_bvalid  = bvld;
   assign s_rvalid  = rvld;

   always_comb begin
      s_bresp = '0;
      s_rresp = '0;
      s_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         s_bresp[i*2 +: 2] = rsp(i);
         s_rresp[i*2 +: 2] = rsp(i);
         s_rdata[i*32 +: 32] = rvld[i] ? rdval(i) : 32'h0;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bvld <= '0; rvld <= '0; got_aw <= '0; got_w <= '0; rpend <= '0;
         for (int i = 0; i < 4; i++) rcnt[i] <= 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (s_awvalid[i] & s_awready[i]) last_addr[i] <= s_awaddr[i*32 +: 32];
            if (s_arvalid[i] & s_arready[i]) last_addr[i] <= s_araddr[i*32 +: 32];
            if (s_wvalid[i] & s_wready[i]) last_wd[i] <= s_wdata[i*32 +: 32];
            if (s_awvalid[i] | s_wvalid[i] | s_arvalid[i]) vcnt[i] <= vcnt[i] + 1;
            if (bvld[i] & s_bready[i]) begin
               bvld[i] <= 1'b0;
            end else if ((got_aw[i] | (s_awvalid[i] & s_awready[i])) &
                         (got_w[i] | (s_wvalid[i] & s_wready[i]))) begin
               bvld[i] <= 1'b1; got_aw[i] <= 1'b0; got_w[i] <= 1'b0;
            end else begin
               got_aw[i] <= got_aw[i] | (s_awvalid[i] & s_awready[i]);
               got_w[i]  <= got_w[i] | (s_wvalid[i] & s_wready[i]);
            end
            if (rvld[i] & s_rready[i]) begin
               rvld[i] <= 1'b0;
            end else if (rpend[i]) begin
               if (rcnt[i] != 0) rcnt[i] <= rcnt[i] - 1;
               else begin rvld[i] <= 1'b1; rpend[i] <= 1'b0; end
            end else if (s_arvalid[i] & s_arready[i]) begin
               rpend[i] <= 1'b1; rcnt[i] <= rdly(i);
            end
         end
      end
   end

   initial for (int i = 0; i < 4; i++) vcnt[i] = 0;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_wr(input logic [31:0] a, input logic [31:0] d,
                        output logic [1:0] r, output int lat);
      int n;
      @(negedge clk);
      m_awaddr = a; m_wdata = d; m_wstrb = 4'hF;
      m_awvalid = 1'b1; m_wvalid = 1'b1;
      #1;
      n = 0;
      while (!m_awready && n < 100) begin @(negedge clk); #1; n++; end
      check("wr_accept", {63'd0, m_awready & m_wready}, 64'd1);
      @(posedge clk); #1;
      m_awvalid = 1'b0; m_wvalid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!m_bvalid && lat < 200);
      check("wr_bvalid", {63'd0, m_bvalid}, 64'd1);
      r = m_bresp;
   endtask

   task automatic do_rd(input logic [31:0] a, output logic [31:0] d,
                        output logic [1:0] r, output int lat);
      int n;
      @(negedge clk);
      m_araddr = a; m_arvalid = 1'b1;
      #1;
      n = 0;
      while (!m_arready && n < 100) begin @(negedge clk); #1; n++; end
      check("rd_accept", {63'd0, m_arready}, 64'd1);
      @(posedge clk); #1;
      m_arvalid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!m_rvalid && lat < 200);
      check("rd_rvalid", {63'd0, m_rvalid}, 64'd1);
      r = m_rresp; d = m_rdata;
   endtask

   // One simultaneous write/read pair; reports which one was taken first
   task automatic race(output logic first_wr);
      int n;
      @(negedge clk);
      m_awaddr = 32'h0000_0040; m_wdata = 32'h5555_0000; m_wstrb = 4'hF;
      m_araddr = 32'h0001_0040;
      m_awvalid = 1'b1; m_wvalid = 1'b1; m_arvalid = 1'b1;
      #1;
      n = 0;
      while (!(m_awready | m_arready) && n < 100) begin @(negedge clk); #1; n++; end
      first_wr = m_awready;
      @(posedge clk); #1;
      if (first_wr) begin m_awvalid = 1'b0; m_wvalid = 1'b0; end
      else m_arvalid = 1'b0;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!(m_awready | m_arready) && n < 100);
      check("race_second_accept", {63'd0, m_awready | m_arready}, 64'd1);
      @(posedge clk); #1;
      m_awvalid = 1'b0; m_wvalid = 1'b0; m_arvalid = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
      int          slave;
      int          lat;
   } vec_t;

   vec_t tbl[8];
   logic [1:0] r;
   logic [31:0] d;
   int lat, n;
   int snap[4];
   logic [3:0] seen, exp_mask;
   logic fw;
   logic [3:0] exp_order;

   initial begin
      tbl[0] = '{1'b1, 32'h0002_0010, 32'hA5A5_A5A5, 2'b00, 2, 3};
      tbl[1] = '{1'b0, 32'h0003_0004, 32'h1234_5678, 2'b00, 3, 9};
      tbl[2] = '{1'b0, 32'h0004_0000, 32'h0000_0000, 2'b11, -1, 1};
      tbl[3] = '{1'b1, 32'h0000_0100, 32'h0BAD_F00D, 2'b01, 0, 3};
      tbl[4] = '{1'b0, 32'h0000_0008, 32'hA000_0000, 2'b01, 0, 4};
      tbl[5] = '{1'b1, 32'h0010_0000, 32'h0000_0077, 2'b11, -1, 1};
      tbl[6] = '{1'b0, 32'h0001_FFFC, 32'hA000_0001, 2'b00, 1, 4};
      tbl[7] = '{1'b1, 32'h0003_FFFF, 32'h0000_0001, 2'b00, 3, 3};
      exp_order = 4'b0101;

      m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0;
      m_awvalid = 1'b0; m_wvalid = 1'b0; m_arvalid = 1'b0;
      m_bready = 1'b1; m_rready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_master_hs", {58'd0, m_awready, m_wready, m_arready,
            m_bvalid, m_rvalid, 1'b0}, 64'd0);
      check("rst_resp_data", {28'd0, m_bresp, m_rresp, m_rdata}, 64'd0);
      check("rst_slave_hs", {44'd0, s_awvalid, s_wvalid, s_arvalid,
            s_bready, s_rready}, 64'd0);
      check("rst_stat", {48'd0, stat}, 64'd0);
      rst = 1'b0;

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 4; i++) snap[i] = vcnt[i];
         if (tbl[k].wr) do_wr(tbl[k].addr, tbl[k].data, r, lat);
         else do_rd(tbl[k].addr, d, r, lat);
         check($sformatf("v%0d_resp", k), {62'd0, r}, {62'd0, tbl[k].resp});
         check($sformatf("v%0d_lat", k), 64'(lat), 64'(tbl[k].lat));
         if (!tbl[k].wr)
            check($sformatf("v%0d_rdata", k), {32'd0, d}, {32'd0, tbl[k].data});
         for (int i = 0; i < 4; i++) begin
            seen[i] = (vcnt[i] != snap[i]);
            exp_mask[i] = (tbl[k].slave == i);
         end
         check($sformatf("v%0d_slave_mask", k), {60'd0, seen}, {60'd0, exp_mask});
         if (tbl[k].slave >= 0) begin
            check($sformatf("v%0d_fwd_addr", k),
                  {32'd0, last_addr[tbl[k].slave]}, {32'd0, tbl[k].addr});
            if (tbl[k].wr)
               check($sformatf("v%0d_wdata", k),
                     {32'd0, last_wd[tbl[k].slave]}, {32'd0, tbl[k].data});
         end
      end

      for (int k = 0; k < 4; k++) begin
         race(fw);
         check($sformatf("race%0d_write_first", k), {63'd0, fw},
               {63'd0, exp_order[k]});
      end

      w_en = 4'b1101;
      do_wr(32'h0001_0000, 32'hDEAD_BEEF, r, lat);
      check("to_bresp", {62'd0, r}, 64'h2);
      check("to_lat_ge16", {63'd0, lat >= 16 && lat <= 20}, 64'd1);
      check("to_stat", {48'd0, stat}, 64'd1);
      @(negedge clk); #1;
      check("to_drain_bready", {60'd0, s_bready}, 64'h2);
      check("to_no_valids", {52'd0, s_awvalid, s_wvalid, s_arvalid}, 64'd0);
      w_en = 4'hF;

      @(negedge clk);
      m_araddr = 32'h0003_0004; m_arvalid = 1'b1;
      #1;
      n = 0;
      while (!m_arready && n < 100) begin @(negedge clk); #1; n++; end
      @(posedge clk); #1;
      m_arvalid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_rready[3] && n < 50);
      check("rr_reached_rd_rsp", {63'd0, s_rready[3]}, 64'd1);
      rst = 1'b1;
      #1;
      check("rr_valids_zero", {50'd0, m_bvalid, m_rvalid, s_awvalid,
            s_wvalid, s_arvalid}, 64'd0);
      check("rr_readies_zero", {56'd0, s_bready, s_rready}, 64'd0);
      check("rr_stat_cleared", {48'd0, stat}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      do_rd(32'h0003_0004, d, r, lat);
      check("rr_next_rdata", {32'd0, d}, 64'h1234_5678);
      check("rr_next_rresp", {62'd0, r}, 64'd0);
      check("rr_next_lat", 64'(lat), 64'd9);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
